// File: rtl/inst_mem_loader_if.sv
// ============================================================================
// inst_mem_loader_if : host/memory-side bus of the instruction memory loader
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface inst_mem_loader_if #(
  parameter int width    = 9,
  parameter int addrBits = 5
);
  logic                START;
  logic [addrBits:0]   LOAD_COUNT;
  logic                IN_VALID;
  logic [width-1:0]    IN_DATA;
  logic                IN_READY;
  logic                WR_EN;
  logic [addrBits-1:0] WR_ADDR;
  logic [width-1:0]    WR_DATA;
  logic                BUSY;
  logic                DONE;
  logic                RUN;
  logic                ERR;

  modport master (
    output START, LOAD_COUNT, IN_VALID, IN_DATA,
    input  IN_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, RUN, ERR
  );

  modport slave (
    input  START, LOAD_COUNT, IN_VALID, IN_DATA,
    output IN_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, RUN, ERR
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
// inst_mem_loader : streams LOAD_COUNT words into instruction memory, then
// releases the processor. Optional checksum word via LOADER_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module inst_mem_loader #(
  parameter int width    = 9,
  parameter int depth    = 32,
  parameter int addrBits = 5
) (
  input  logic              clk,
  input  logic              resetn,
  inst_mem_loader_if.slave  bus
);

  localparam int CW = addrBits + 1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    CHECK = 2'd3,
`endif
    FIN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [addrBits-1:0] addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [addrBits-1:0] wr_addr_q, wr_addr_d;
  logic [width-1:0]    wr_data_q, wr_data_d;
  logic                run_q, run_d;
  logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [width-1:0]    chk_q, chk_d;
`endif

  logic in_ready;
  logic handshake;
  logic last_word;

  // Ready is a pure decode of registered state, so it never depends on IN_VALID.
`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == LOAD) || (state_q == CHECK);
`else
  assign in_ready = (state_q == LOAD);
`endif
  assign handshake = bus.IN_VALID & in_ready;
  assign last_word = ({1'b0, addr_q} == (count_q - CW'(1)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    run_d     = run_q;
    err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          run_d = 1'b0;
          if ((bus.LOAD_COUNT != '0) && (bus.LOAD_COUNT <= MAX_COUNT)) begin
            count_d = bus.LOAD_COUNT;
            addr_d  = '0;
            err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (handshake) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.IN_DATA;
`ifdef LOADER_CHECKSUM_EN
          chk_d     = chk_q ^ bus.IN_DATA;
`endif
          // Counter parks on the last address instead of stepping past it.
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = FIN;
`endif
          end else begin
            addr_d = addr_q + addrBits'(1);
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (handshake) begin
          if (bus.IN_DATA == chk_q) begin
            state_d = FIN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      FIN: begin
        run_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      run_q     <= run_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.WR_EN    = wr_en_q;
  assign bus.WR_ADDR  = wr_addr_q;
  assign bus.WR_DATA  = wr_data_q;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = (state_q == FIN);
  assign bus.RUN      = run_q;
  assign bus.ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
// tb_inst_mem_loader : randomized scoreboard bench for inst_mem_loader
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_mem_loader;

  localparam int W  = 9;
  localparam int AB = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  inst_mem_loader_if #(.width(W), .addrBits(AB)) bus ();

  inst_mem_loader #(.width(W), .depth(32), .addrBits(AB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [W-1:0]  data;
    longint        cyc;
  } exp_t;

  exp_t         exp_q[$];
  longint       cyc = 0;
  int           done_cnt = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] words [0:31];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  logic [AB-1:0] prev_addr = '0;
  logic [W-1:0]  prev_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      prev_addr = '0;
      prev_data = '0;
    end else begin
      if (bus.DONE === 1'b1) done_cnt++;
      if (bus.WR_EN === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_en", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.WR_ADDR), 32'(e.addr));
          check("wr_data", 32'(bus.WR_DATA), 32'(e.data));
          check("wr_latency", 32'(cyc), 32'(e.cyc));
        end
        prev_addr = bus.WR_ADDR;
        prev_data = bus.WR_DATA;
      end else begin
        check("wr_addr_hold", 32'(bus.WR_ADDR), 32'(prev_addr));
        check("wr_data_hold", 32'(bus.WR_DATA), 32'(prev_data));
      end
    end
  end

  task automatic start_pulse(input int n);
    bus.START      = 1'b1;
    bus.LOAD_COUNT = 6'(n);
    @(negedge clk);
    bus.START      = 1'b0;
    bus.LOAD_COUNT = 6'($urandom);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_wr, input int addr);
    int t = 0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = w;
    while (bus.IN_READY !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      bus.IN_VALID = 1'b0;
      return;
    end
    if (expect_wr) exp_q.push_back('{AB'(addr), w, cyc + 1});
    @(negedge clk);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      bus.IN_VALID = 1'b0;
      bus.IN_DATA  = W'($urandom);
      @(negedge clk);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each word, 2 random.
  task automatic run_session(input int n, input int gap_mode, input bit glitch, input bit bad_chk);
    int           d0 = done_cnt;
    logic [W-1:0] x  = '0;
    start_pulse(n);
    check("busy_after_start", 32'(bus.BUSY), 32'd1);
    check("err_cleared", 32'(bus.ERR), 32'd0);
    check("run_cleared", 32'(bus.RUN), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gap_mode == 1) idle_gap(1);
      else if (gap_mode == 2) idle_gap($urandom_range(3));
      if (glitch && i == n / 2) start_pulse(1);
      send_word(words[i], 1'b1, i);
      x = x ^ words[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(bad_chk ? (x ^ W'(1)) : x, 1'b0, 0);
`endif
    check("in_ready_after_last", 32'(bus.IN_READY), 32'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), bad_chk ? 32'd0 : 32'd1);
    check("run_level", 32'(bus.RUN), bad_chk ? 32'd0 : 32'd1);
    check("err_level", 32'(bus.ERR), bad_chk ? 32'd1 : 32'd0);
    check("busy_idle", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd0);
    check({tag, "_wr_en"},    32'(bus.WR_EN),    32'd0);
    check({tag, "_busy"},     32'(bus.BUSY),     32'd0);
    check({tag, "_done"},     32'(bus.DONE),     32'd0);
    check({tag, "_run"},      32'(bus.RUN),      32'd0);
    check({tag, "_err"},      32'(bus.ERR),      32'd0);
    check({tag, "_wr_addr"},  32'(bus.WR_ADDR),  32'd0);
    check({tag, "_wr_data"},  32'(bus.WR_DATA),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.START      = 1'b0;
    bus.LOAD_COUNT = '0;
    bus.IN_VALID   = 1'b0;
    bus.IN_DATA    = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    words[0] = 9'h101; words[1] = 9'h0A5; words[2] = 9'h1FF;
    run_session(3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 32; i++) words[i] = W'($urandom);
    run_session(32, 1, 1'b0, 1'b0);

    start_pulse(0);
    check("err_count0", 32'(bus.ERR), 32'd1);
    check("busy_count0", 32'(bus.BUSY), 32'd0);
    check("run_count0", 32'(bus.RUN), 32'd0);
    start_pulse(33);
    check("err_count33", 32'(bus.ERR), 32'd1);
    check("busy_count33", 32'(bus.BUSY), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) words[i] = W'($urandom);
    run_session(4, 2, 1'b0, 1'b0);

    // Abort after two of five words with an asynchronous reset.
    for (int i = 0; i < 5; i++) words[i] = W'($urandom);
    start_pulse(5);
    send_word(words[0], 1'b1, 0);
    send_word(words[1], 1'b1, 1);
    #2 resetn = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    words[0] = W'($urandom);
    run_session(1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) words[i] = W'($urandom);
    run_session(10, 2, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    words[0] = 9'h003; words[1] = 9'h005;
    run_session(2, 0, 1'b0, 1'b0);
    run_session(2, 0, 1'b0, 1'b1);
`endif

    for (int s = 0; s < 6; s++) begin
      int n = $urandom_range(32, 1);
      for (int i = 0; i < n; i++) words[i] = W'($urandom);
      run_session(n, 2, s[0], 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter width, default 9, SHALL set the instruction word width in bits.
REQ-002 Parameter depth, default 32, SHALL set the number of instruction memory words.
REQ-003 Parameter addrBits, default 5, SHALL set the memory address width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 START  input  1  SHALL begin a load session when high for one cycle in IDLE.
REQ-007 LOAD_COUNT  input  addrBits+1  SHALL give the number of words to load; sampled only when START is accepted.
REQ-008 IN_VALID  input  1  SHALL indicate that IN_DATA holds a valid word.
REQ-009 IN_DATA  input  width  SHALL carry the instruction word.
REQ-010 IN_READY  output  1  SHALL indicate that the loader accepts a word this cycle.
REQ-011 WR_EN  output  1  SHALL be the write strobe to the instruction memory.
REQ-012 WR_ADDR  output  addrBits  SHALL be the write address.
REQ-013 WR_DATA  output  width  SHALL be the write data.
REQ-014 BUSY  output  1  SHALL be high while a load session is in progress.
REQ-015 DONE  output  1  SHALL pulse high for exactly one cycle when a session completes successfully.
REQ-016 RUN  output  1  SHALL release the processor; level signal.
REQ-017 ERR  output  1  SHALL flag a rejected or failed session; sticky.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, CHECK (present only under REQ-034) and FIN.
REQ-019 In IDLE, START=1 with 1 <= LOAD_COUNT <= depth SHALL latch LOAD_COUNT, clear the address counter to 0, clear ERR and RUN, and enter LOAD on the next edge.
REQ-020 In IDLE, START=1 with LOAD_COUNT=0 or LOAD_COUNT>depth SHALL set ERR, clear RUN, and remain in IDLE.
REQ-021 START SHALL be ignored in any state other than IDLE.
REQ-022 IN_READY SHALL be 1 only in LOAD and SHALL be decoded from registered state, with no combinational path from IN_VALID.
REQ-023 A handshake (IN_VALID & IN_READY) at edge N SHALL produce WR_EN=1, WR_ADDR=counter value, and WR_DATA=IN_DATA during cycle N+1 (one-cycle latency); the counter then increments.
REQ-024 WR_EN SHALL be 0 in every cycle that does not follow a handshake; WR_ADDR and WR_DATA SHALL hold their values when WR_EN=0.
REQ-025 The handshake on word LOAD_COUNT-1 SHALL move the FSM to FIN, or to CHECK when REQ-034 applies; the address counter SHALL never wrap past depth-1.
REQ-026 IN_VALID gaps in LOAD SHALL stall the session without limit and without side effects.
REQ-027 FIN SHALL last one cycle: DONE=1, then RUN=1 on return to IDLE; RUN SHALL stay high until the next accepted START or reset.
REQ-028 BUSY SHALL be 1 in LOAD, CHECK and FIN, and 0 in IDLE.

Reset
REQ-029 Asserting resetn low SHALL force IDLE asynchronously, with the address counter at 0 and IN_READY, WR_EN, BUSY, DONE, RUN and ERR all at 0.
REQ-030 WR_ADDR and WR_DATA SHALL reset to 0.
REQ-031 Reset mid-session SHALL abort with no further WR_EN; partially written memory contents are not restored.
REQ-032 After resetn deasserts, the first START SHALL be honoured no earlier than the next rising edge.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-034 With LOADER_CHECKSUM_EN defined, the loader SHALL XOR all loaded words and then enter CHECK, which accepts one extra handshake word (IN_READY=1, WR_EN=0); if that word equals the XOR, the FSM enters FIN, otherwise ERR=1, no DONE, RUN stays 0, and the FSM returns to IDLE.
REQ-035 Without LOADER_CHECKSUM_EN, the CHECK state and the checksum register SHALL not exist, and the FSM SHALL go LOAD->FIN directly.

Verification
REQ-036 Reset, then START with LOAD_COUNT=3 and words 0x101, 0x0A5, 0x1FF sent back-to-back -> WR_ADDR 0,1,2 with matching WR_DATA on consecutive cycles, one DONE pulse, RUN=1.
REQ-037 LOAD_COUNT=32 with IN_VALID toggling every other cycle -> 32 writes at addresses 0..31, no wrap, and IN_READY=0 after the last word.
REQ-038 START with LOAD_COUNT=0, then with 33 -> ERR=1, BUSY=0, WR_EN never asserted; a following valid START clears ERR.
REQ-039 resetn pulsed low after 2 of 5 words -> all outputs 0 immediately; a new START with LOAD_COUNT=1 loads address 0.
REQ-040 With LOADER_CHECKSUM_EN and words 0x003, 0x005: checksum 0x006 -> DONE and RUN=1; checksum 0x007 -> ERR=1, RUN=0.
REQ-041 START pulsed during LOAD -> ignored; LOAD_COUNT and the address sequence are unchanged.
